// File: rtl/fan_pkg.sv
// Shared constants, state encoding and duty helpers for the fan PWM driver slice.
package fan_pkg;

  localparam int unsigned DUTY_MAX         = 100;
  localparam int unsigned DUTY_W           = 7;
  localparam int unsigned STEPS_PER_PERIOD = 100;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [7:0] DUTY_MAX8 = 8'(DUTY_MAX);

  // Widen to 8 bits so later ramp arithmetic cannot wrap in 7 bits.
  function automatic logic [7:0] clamp_duty(input logic [DUTY_W-1:0] d);
    logic [7:0] d8;
    d8 = {1'b0, d};
    return (d8 > DUTY_MAX8) ? DUTY_MAX8 : d8;
  endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// Prescaler plus 0..99 step counter; emits per-step and end-of-period ticks.
module fan_tick_gen
  import fan_pkg::*;
#(
  parameter int unsigned PRESCALE = 50
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              en,
  output logic [DUTY_W-1:0] step_cnt,
  output logic              step_tick,
  output logic              period_tick
);

  localparam logic [15:0]       PRE_LAST  = 16'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] STEP_LAST = DUTY_W'(STEPS_PER_PERIOD - 1);

  logic [15:0] pre_cnt;

  // Gated so no tick escapes while held in reset or disabled.
  assign step_tick   = !reset_p && en && (pre_cnt == PRE_LAST);
  assign period_tick = step_tick && (step_cnt == STEP_LAST);

  always_ff @(posedge clk) begin
    if (reset_p || !en) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else if (step_tick) begin
      pre_cnt  <= '0;
      step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
    end else begin
      pre_cnt  <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan PWM driver: ramps the applied duty toward a per-period sampled target
// and drives a registered PWM output compared against the step counter.
module fan_pwm_driver
  import fan_pkg::*;
#(
  parameter int unsigned PRESCALE = 50,
  parameter int unsigned RAMP_INC = 5
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm,
  output logic [DUTY_W-1:0] duty_cur,
  output logic              busy,
  output logic              period_tick
);

  localparam logic [7:0] INC = 8'(RAMP_INC);

  logic [DUTY_W-1:0] step_cnt;
  logic [DUTY_W-1:0] tgt;
  logic              step_tick;
  logic              tick_period;
  logic              period_end;
  logic [1:0]        state;
  logic [7:0]        cur8;
  logic [7:0]        tgt_next;
  logic [7:0]        cur_next;
  logic [7:0]        diff;

  fan_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk         (clk),
    .reset_p     (reset_p),
    .en          (en),
    .step_cnt    (step_cnt),
    .step_tick   (step_tick),
    .period_tick (tick_period)
  );

  assign period_tick = tick_period;
  assign period_end  = step_tick && tick_period;

  // Step size is limited to the remaining distance, so the target is never overshot.
  always_comb begin
    cur8     = {1'b0, duty_cur};
    tgt_next = clamp_duty(duty);
    cur_next = cur8;
    diff     = '0;
    if (cur8 < tgt_next) begin
      diff     = tgt_next - cur8;
      cur_next = cur8 + ((diff < INC) ? diff : INC);
    end else if (cur8 > tgt_next) begin
      diff     = cur8 - tgt_next;
      cur_next = cur8 - ((diff < INC) ? diff : INC);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p || !en) begin
      duty_cur <= '0;
      tgt      <= '0;
      pwm      <= 1'b0;
    end else begin
      pwm <= (step_cnt < duty_cur);
      if (period_end) begin
        duty_cur <= cur_next[DUTY_W-1:0];
        tgt      <= tgt_next[DUTY_W-1:0];
      end
    end
  end

  always_comb begin
    if (duty_cur != tgt)     state = ST_RAMP;
    else if (duty_cur == '0) state = ST_OFF;
    else                     state = ST_RUN;
  end

  assign busy = (state == ST_RAMP);

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Scoreboard bench for fan_pwm_driver (PRESCALE=2): a cycle model pushes expected
// outputs per clock, popped and compared after the edge, plus scenario checks.
module tb_fan_pwm_driver;

  localparam int P = 2;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       en;
  logic [6:0] duty;
  logic [6:0] duty7;
  logic       pwm, busy, period_tick;
  logic [6:0] duty_cur;
  logic       pwm7, busy7, pt7;
  logic [6:0] duty_cur7;

  always #5 clk = ~clk;

  fan_pwm_driver #(.PRESCALE(2), .RAMP_INC(5)) dut (
    .clk(clk), .reset_p(reset_p), .en(en), .duty(duty),
    .pwm(pwm), .duty_cur(duty_cur), .busy(busy), .period_tick(period_tick)
  );

  fan_pwm_driver #(.PRESCALE(2), .RAMP_INC(7)) dut7 (
    .clk(clk), .reset_p(reset_p), .en(en), .duty(duty7),
    .pwm(pwm7), .duty_cur(duty_cur7), .busy(busy7), .period_tick(pt7)
  );

  typedef struct {
    logic       pwm;
    logic [6:0] cur;
    logic       busy;
    logic       pt;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int m_pre = 0, m_step = 0, m_cur = 0, m_tgt = 0;
  bit m_pwm = 1'b0;
  int pwm_acc = 0, pwm7_acc = 0, max_cur = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   t, d;
    bit   pt_now;
    if (reset_p || !en) begin
      m_pre = 0; m_step = 0; m_cur = 0; m_tgt = 0; m_pwm = 1'b0;
    end else begin
      pt_now = (m_pre == P - 1) && (m_step == 99);
      m_pwm  = (m_step < m_cur);
      if (pt_now) begin
        t = (int'(duty) > 100) ? 100 : int'(duty);
        if (m_cur < t) begin
          d = t - m_cur; m_cur += (d < 5) ? d : 5;
        end else if (m_cur > t) begin
          d = m_cur - t; m_cur -= (d < 5) ? d : 5;
        end
        m_tgt = t;
      end
      if (m_pre == P - 1) begin
        m_pre  = 0;
        m_step = (m_step == 99) ? 0 : m_step + 1;
      end else begin
        m_pre++;
      end
    end
    e.pwm  = m_pwm;
    e.cur  = 7'(m_cur);
    e.busy = (m_cur != m_tgt);
    e.pt   = !reset_p && en && (m_pre == P - 1) && (m_step == 99);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("pwm", int'(pwm), int'(e.pwm));
    check("duty_cur", int'(duty_cur), int'(e.cur));
    check("busy", int'(busy), int'(e.busy));
    check("period_tick", int'(period_tick), int'(e.pt));
    check("period_tick7", int'(pt7), int'(e.pt));
    pwm_acc  += int'(pwm);
    pwm7_acc += int'(pwm7);
    if (int'(duty_cur) > max_cur) max_cur = int'(duty_cur);
  endtask

  task automatic wait_for(input string tag, input int target, input int budget);
    int n = 0;
    while (!(int'(duty_cur) == target && !busy) && n < budget) begin
      tick();
      n++;
    end
    check(tag, int'(duty_cur), target);
  endtask

  task automatic wait_pt(input string tag);
    int n = 0;
    while (!period_tick && n < 400) begin
      tick();
      n++;
    end
    check(tag, int'(period_tick), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_p = 1'b1; en = 1'b0; duty = 7'd0; duty7 = 7'd33;
    repeat (3) tick();
    check("rst_pwm", int'(pwm), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_duty_cur", int'(duty_cur), 0);

    // Soft start to 30 (RAMP_INC=5) alongside 33 on the RAMP_INC=7 instance.
    reset_p = 1'b0; en = 1'b1; duty = 7'd30;
    for (int k = 1; k <= 7; k++) begin
      pwm_acc = 0; pwm7_acc = 0;
      repeat (200) tick();
      check("ramp30", int'(duty_cur), (5 * k > 30) ? 30 : 5 * k);
      check("ramp30_busy", int'(busy), (k < 6) ? 1 : 0);
      check("ramp33_inc7", int'(duty_cur7), (7 * k > 33) ? 33 : 7 * k);
    end
    check("pwm_high_30", pwm_acc, 60);
    check("pwm_high_33", pwm7_acc, 66);
    check("busy7_done", int'(busy7), 0);

    duty = 7'd100;
    wait_for("to100", 100, 20 * 200);
    pwm_acc = 0;
    repeat (600) tick();
    check("pwm_high_100", pwm_acc, 600);
    duty = 7'd0;
    wait_for("to0", 0, 25 * 200);
    check("busy_at_0", int'(busy), 0);
    pwm_acc = 0;
    repeat (200) tick();
    check("pwm_high_0", pwm_acc, 0);

    duty = 7'd127;
    max_cur = 0;
    wait_for("clamp", 100, 25 * 200);
    repeat (400) tick();
    check("clamp_max", max_cur, 100);

    duty = 7'd60;
    wait_for("to60", 60, 25 * 200);
    duty = 7'd90;
    repeat (50) tick();
    duty = 7'd30;
    wait_pt("pt_sample");
    tick();
    check("sample_at_tick", int'(duty_cur), 55);
    duty = 7'd90;
    wait_pt("pt_reverse");
    tick();
    check("reversal", int'(duty_cur), 60);
    check("reversal_busy", int'(busy), 1);
    wait_for("to90", 90, 25 * 200);

    en = 1'b0;
    tick();
    check("en_off_pwm", int'(pwm), 0);
    check("en_off_duty", int'(duty_cur), 0);
    check("en_off_busy", int'(busy), 0);
    en = 1'b1;
    wait_pt("pt_soft");
    tick();
    check("soft_start", int'(duty_cur), 5);

    repeat (37) tick();
    reset_p = 1'b1; en = 1'b0;
    tick();
    check("midrst_pwm", int'(pwm), 0);
    check("midrst_duty", int'(duty_cur), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_pt", int'(period_tick), 0);
    reset_p = 1'b0; en = 1'b1;
    n = 1;
    while (!period_tick && n < 400) begin
      tick();
      n++;
    end
    check("pt_after_rst", n, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fan_pwm_driver.md
FAN_PWM_DRIVER -- requirements
Module: fan_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 50, is the number of clk cycles per PWM step (legal range 1..65535).
REQ-002 Parameter RAMP_INC, default 5, is the maximum change of the applied duty per PWM period (legal range 1..100).
REQ-003 The block SHALL have exactly one clock and a synchronous, active-high reset, with ports as listed below.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset_p  input  1  synchronous, active-high reset.
REQ-006 en  input  1  fan enable; low forces the output off.
REQ-007 duty  input  7  requested duty in percent (0..100), e.g. 0/30/60/90 from the speed selector; values above 100 are treated as 100.
REQ-008 pwm  output  1  fan PWM drive, registered.
REQ-009 duty_cur  output  7  duty currently applied (0..100).
REQ-010 busy  output  1  high while ramping toward the target.
REQ-011 period_tick  output  1  one-cycle pulse on the last clk of each PWM period.

Function
REQ-012 Prescaler pre_cnt SHALL count 0..PRESCALE-1 and wrap; step_tick is asserted when pre_cnt==PRESCALE-1.
REQ-013 Step counter step_cnt SHALL count 0..99, advancing on step_tick and wrapping 99->0, so one period is 100*PRESCALE clk cycles.
REQ-014 period_tick SHALL be asserted for exactly the cycle in which step_tick is high and step_cnt==99.
REQ-015 Each cycle, pwm SHALL be loaded with (step_cnt < duty_cur), so pwm lags the counters by one clk.
REQ-016 With duty_cur==0, pwm SHALL stay constantly low; with duty_cur==100, it SHALL stay constantly high, with no glitch at wrap.
REQ-017 Target tgt = min(duty,100) SHALL be sampled only in period_tick cycles; changes to duty mid-period SHALL have no effect until the next period end.
REQ-018 In a period_tick cycle, if duty_cur<tgt, duty_cur SHALL increase by min(RAMP_INC, tgt-duty_cur).
REQ-019 In a period_tick cycle, if duty_cur>tgt, duty_cur SHALL decrease by min(RAMP_INC, duty_cur-tgt).
REQ-020 duty_cur SHALL never overshoot tgt and never leave 0..100; arithmetic SHALL use 8 bits internally to avoid 7-bit wrap.
REQ-021 The state machine SHALL have the states OFF, RAMP and RUN, evaluated on the registered duty_cur and tgt.
REQ-022 OFF: duty_cur==0 and tgt==0.
REQ-023 RAMP: duty_cur!=tgt.
REQ-024 RUN: duty_cur==tgt!=0.
REQ-025 busy SHALL be high exactly in RAMP.
REQ-026 While en==0, the block SHALL force pre_cnt=0, step_cnt=0, duty_cur=0, tgt=0, pwm=0 and period_tick=0 on every clk; the state is OFF.
REQ-027 When en rises, counting SHALL start from 0 on the next clk, and the first target sample occurs at the first period end (soft start from 0).
REQ-028 If duty changes direction mid-ramp, the ramp SHALL reverse at the next period_tick using the newly sampled tgt.

Reset
REQ-029 While reset_p==1 at a clk edge, the block SHALL clear pre_cnt, step_cnt, duty_cur and tgt, and force pwm=0, busy=0 and period_tick=0 (state OFF).
REQ-030 Reset SHALL take priority over en.
REQ-031 Reset asserted mid-period or mid-ramp SHALL abort the ramp, after which the block restarts as if from power-up.

Structure
REQ-032 Shared package fan_pkg SHALL hold DUTY_MAX=100, DUTY_W=7, STEPS_PER_PERIOD=100 and the state encoding (OFF/RAMP/RUN).
REQ-033 The prescaler and step counter SHALL be one sub-module, fan_tick_gen, with outputs step_cnt, step_tick and period_tick; ramp, FSM and compare logic stay in fan_pwm_driver.

Verification (PRESCALE=2, RAMP_INC=5 unless stated)
REQ-034 Reset release, en=1, duty=30 -> duty_cur steps 0,5,10,...,30 over 6 periods (200 clk each), busy=1 throughout, then busy=0; after that, pwm is high 60 clk and low 140 clk per period.
REQ-035 duty=100 held until RUN -> pwm constantly high for 3 full periods; then duty=0 -> pwm constantly low once ramped down to 0, busy falls with duty_cur=0.
REQ-036 duty=127 -> tgt clamps to 100, duty_cur never exceeds 100; with RAMP_INC=7, duty=33 from 0 -> 7,14,21,28,33 (no overshoot).
REQ-037 In RUN at 60, duty changes to 90 then back to 30 within the same period -> only the value present at period_tick is used; a mid-ramp reversal turns the ramp at the next period end.
REQ-038 en dropped in RUN at 90 -> the next clk gives pwm=0 and duty_cur=0; en re-raised -> soft start from 0 again.
REQ-039 reset_p pulsed for 1 clk mid-ramp with en=0 at the same time -> all outputs return to their reset values; period_tick reappears 200 clk after release.
